fp_reduce_nch: RTL
==================

# fp_reduce_nch

Parametrised FP32 sum-reduction engine for the Adder_NChannel group. It sums NUM_CH single-precision channels into one value using a single time-multiplexed FP_Adder instance instead of a combinational tree of adders. It has valid/ready handshakes on both sides, so it can sit between a convolution MAC array and the activation stage. An optional compile-time accumulate mode sums several consecutive input vectors before emitting a result.

## Interface
- NUM_CH, default 32, number of FP32 channels per input vector; legal range 2..64, need not be a power of two
- DATA_W, default 32, word width; fixed at 32 (IEEE-754 single)
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- In_Data  input  NUM_CH*32  flattened channels; channel i occupies [32i+31:32i]
- In_Valid  input  1  input vector valid
- In_Ready  output  1  block can accept a vector
- In_Last  input  1  last vector of an accumulation group; ignored unless FP_REDUCE_ACCUM_EN is defined
- RMode  input  2  rounding mode for FP_Adder; sampled on input acceptance and held for the whole reduction
- Out_Data  output  32  FP32 sum
- Out_Valid  output  1  Out_Data valid
- Out_Ready  input  1  downstream accepts Out_Data

## Operation
- Storage:
  - Buffer of NUM_CH x 32 registers, loaded from In_Data on acceptance (In_Valid & In_Ready).
  - One FP_Adder instance, with Mode=0 and RMode driven from the sampled RMode register.
- FSM states and transitions:
  - IDLE: In_Ready=1. On acceptance, load the buffer, set level count n=NUM_CH and pair index i=0, then go to ISSUE.
  - ISSUE:
    - Drive buf[2i], buf[2i+1] to the adder with Valid_In=1 for exactly one cycle, then go to WAIT.
    - If n is odd and i = (n-1)/2, do not add: copy buf[n-1] to buf[i] in this cycle.
  - WAIT: Valid_In=0. When adder Valid_Out=1, write the result to buf[i] and advance i. At the end of a level, set n=ceil(n/2) and i=0. If n=1, go to DONE (or ACC, see Configuration); otherwise go to ISSUE.
  - DONE: Out_Valid=1 and Out_Data=buf[0]. Go to IDLE on Out_Ready=1.
- Addition order is a fixed pairwise tree over adjacent channels: ((c0+c1)+(c2+c3))+... For odd levels, the last element is carried up unchanged. Results must be bit-exact to this order.
- Total adder operations per vector: NUM_CH-1.
- Adder Valid_Out outside WAIT is ignored. The FP_Adder latency (L cycles, L>=1) is not hard-coded; the FSM follows Valid_Out.

## Timing
- Reset values: In_Ready=0 while rst_n=0, then 1 from the first cycle after release. Out_Valid=0. Out_Data=0. FSM=IDLE. Buffer and accumulator cleared.
- Input to output latency, measured from the acceptance edge to the first cycle Out_Valid=1: (NUM_CH-1)*(L+1) + C + 1 cycles.
  - C is the number of odd-carry cycles.
  - Example: NUM_CH=32, L=1 gives 63 cycles.
- In_Ready is 0 from acceptance until the cycle after the output handshake. There is no overlap of input acceptance with DONE.
- Out_Data and Out_Valid are held stable while Out_Ready=0.
- rst_n asserted in any state: return to IDLE immediately and discard the in-flight adder result and partial sums.

## Configuration
- FP_REDUCE_ACCUM_EN defined:
  - Adds an accumulator register, a first-of-group flag, and an ACC state after the tree.
  - ACC behaviour: the first vector of a group copies buf[0] into acc. Later vectors issue acc+buf[0] through the same adder (L+1 cycles).
  - Group end: if In_Last was sampled for that vector, go to DONE with Out_Data=acc and re-arm the first-of-group flag. Otherwise go to IDLE with no output.
- FP_REDUCE_ACCUM_EN undefined: no accumulator, no ACC state; In_Last is ignored, and every accepted vector produces one output.

## Test plan
- NUM_CH=4, channels 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000) -> Out_Data=0x41200000 (10.0), Out_Valid after the computed latency.
- NUM_CH=5, channels 1.0..5.0 -> 0x41700000 (15.0); carry path exercised on level n=5 and n=3.
- NUM_CH=32, all channels 0x3F800000 -> 0x42000000 (32.0); hold Out_Ready=0 for 5 cycles -> Out_Data stable and In_Ready=0 throughout, then IDLE one cycle after Out_Ready=1.
- FP_REDUCE_ACCUM_EN, NUM_CH=4:
  - Vector of four 1.0 with In_Last=0 -> no Out_Valid.
  - Next vector of four 1.0 with In_Last=1 -> 0x41000000 (8.0).
  - Third vector of 2.0 with In_Last=1 -> 0x41000000 (new group).
- Assert rst_n=0 mid-WAIT -> Out_Valid=0 immediately and In_Ready=1 after release. The next vector 1.0..4.0 yields 10.0 with no stale partial sums.

Source files
------------

// File: rtl/fp_reduce_nch.sv
// FP32 sum-reduction over NUM_CH channels using one time-multiplexed FP_Adder (pairwise adjacent tree).
// Optional FP_REDUCE_ACCUM_EN adds an accumulator that sums consecutive vectors until In_Last.

module FP_Adder #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Mode,
  input  logic [1:0]  RMode,
  input  logic        Valid_In,
  output logic [31:0] Result,
  output logic        Valid_Out
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] r;
    r = 5'd27;
    for (int k = 0; k < 27; k++) if (v[k]) r = 5'(26 - k);
    return r;
  endfunction

  logic        sa, sb, sx, sy, eff_sub;
  logic [7:0]  ea, eb, ex, ey, dexp, dsh;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [23:0] mx, my;
  logic [53:0] sh;
  logic [26:0] my_al, m_n;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e_n, e_r, shamt;
  logic        g, st, inc, to_inf;
  logic [24:0] rnd;
  logic [31:0] res_c;

  always_comb begin
    sa = A[31];
    sb = B[31] ^ Mode;
    ea = A[30:23];
    eb = B[30:23];
    fa = A[22:0];
    fb = B[22:0];
    a_nan = (ea == 8'hFF) && (fa != 23'd0);
    b_nan = (eb == 8'hFF) && (fb != 23'd0);
    a_inf = (ea == 8'hFF) && (fa == 23'd0);
    b_inf = (eb == 8'hFF) && (fb == 23'd0);
    // x is the operand of larger magnitude; denormals use effective exponent 1
    if (A[30:0] >= B[30:0]) begin
      sx = sa; ex = (ea == 8'd0) ? 8'd1 : ea; mx = {ea != 8'd0, fa};
      sy = sb; ey = (eb == 8'd0) ? 8'd1 : eb; my = {eb != 8'd0, fb};
    end else begin
      sx = sb; ex = (eb == 8'd0) ? 8'd1 : eb; mx = {eb != 8'd0, fb};
      sy = sa; ey = (ea == 8'd0) ? 8'd1 : ea; my = {ea != 8'd0, fa};
    end
    eff_sub = sx ^ sy;
    dexp = ex - ey;
    dsh = (dexp > 8'd27) ? 8'd27 : dexp;
    sh = {my, 3'b000, 27'd0} >> dsh;
    my_al = sh[53:27] | {26'd0, |sh[26:0]};
    if (eff_sub) sum = {1'b0, mx, 3'b000} - {1'b0, my_al};
    else         sum = {1'b0, mx, 3'b000} + {1'b0, my_al};
    lz = lzc27(sum[26:0]);
    shamt = 10'd0;
    if (sum[27]) begin
      m_n = {sum[27:2], sum[1] | sum[0]};
      e_n = {2'b00, ex} + 10'd1;
    end else begin
      shamt = ({5'd0, lz} < ({2'b00, ex} - 10'd1)) ? {5'd0, lz} : ({2'b00, ex} - 10'd1);
      m_n = sum[26:0] << shamt;
      e_n = {2'b00, ex} - shamt;
    end
    g  = m_n[2];
    st = |m_n[1:0];
    case (RMode)
      2'd0:    inc = g & (st | m_n[3]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = sx & (g | st);
      default: inc = ~sx & (g | st);
    endcase
    rnd = {1'b0, m_n[26:3]} + {24'd0, inc};
    e_r = rnd[24] ? (e_n + 10'd1) : e_n;
    to_inf = (RMode == 2'd0) || ((RMode == 2'd3) && !sx) || ((RMode == 2'd2) && sx);

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) res_c = 32'h7FC0_0000;
    else if (a_inf)                                       res_c = {sa, 8'hFF, 23'd0};
    else if (b_inf)                                       res_c = {sb, 8'hFF, 23'd0};
    else if (sum == 28'd0)                                res_c = {eff_sub ? (RMode == 2'd2) : sx, 31'd0};
    else if (e_r >= 10'd255)                              res_c = to_inf ? {sx, 8'hFF, 23'd0} : {sx, 8'hFE, 23'h7F_FFFF};
    else res_c = {sx, (rnd[24] | rnd[23]) ? e_r[7:0] : 8'd0, rnd[24] ? rnd[23:1] : rnd[22:0]};
  end

  logic [31:0]    res_q [LAT];
  logic [LAT-1:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) res_q[k] <= '0;
      vld_q <= '0;
    end else begin
      res_q[0] <= res_c;
      vld_q[0] <= Valid_In;
      for (int k = 1; k < LAT; k++) begin
        res_q[k] <= res_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign Result    = res_q[LAT-1];
  assign Valid_Out = vld_q[LAT-1];

endmodule

module fp_reduce_nch #(
  parameter int NUM_CH  = 32,
  parameter int DATA_W  = 32,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] In_Data,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic                     In_Last,
  input  logic [1:0]               RMode,
  output logic [DATA_W-1:0]        Out_Data,
  output logic                     Out_Valid,
  input  logic                     Out_Ready
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
`ifdef FP_REDUCE_ACCUM_EN
    S_ACC,
    S_ACC_W,
`endif
    S_DONE
  } state_e;

`ifdef FP_REDUCE_ACCUM_EN
  localparam state_e S_FIN = S_ACC;
`else
  localparam state_e S_FIN = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [DATA_W-1:0] data_d [NUM_CH];
  logic [6:0]        n_q, n_d, i_q, i_d;
  logic [1:0]        rmode_q, rmode_d;
  logic              run_q;
  logic              carry, level_end;
  logic [7:0]        b8;
  logic [IW-1:0]     idx_i, idx_a, idx_b, idx_last;
  logic [DATA_W-1:0] add_a, add_b, add_res, res_out;
  logic              add_vin, add_vout;

`ifdef FP_REDUCE_ACCUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              first_q, first_d, last_q, last_d, grp_end;
`else
  logic unused_last;
  assign unused_last = In_Last;
`endif

  always_comb begin
    idx_i    = IW'(i_q);
    idx_a    = IW'({i_q, 1'b0});
    b8       = {i_q, 1'b0} + 8'd1;
    if (b8 >= 8'(NUM_CH)) b8 = 8'(NUM_CH - 1);
    idx_b    = IW'(b8);
    idx_last = IW'(n_q - 7'd1);
    // odd level: the last element is carried up instead of being added
    carry    = n_q[0] && (i_q == ((n_q - 7'd1) >> 1));
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    n_d       = n_q;
    i_d       = i_q;
    rmode_d   = rmode_q;
    add_a     = data_q[idx_a];
    add_b     = data_q[idx_b];
    add_vin   = 1'b0;
    level_end = 1'b0;
`ifdef FP_REDUCE_ACCUM_EN
    acc_d     = acc_q;
    first_d   = first_q;
    last_d    = last_q;
    grp_end   = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (In_Valid && run_q) begin
        for (int k = 0; k < NUM_CH; k++) data_d[k] = In_Data[k*DATA_W +: DATA_W];
        n_d     = 7'(NUM_CH);
        i_d     = 7'd0;
        rmode_d = RMode;
`ifdef FP_REDUCE_ACCUM_EN
        last_d  = In_Last;
`endif
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (carry) begin
          data_d[idx_i] = data_q[idx_last];
          level_end     = 1'b1;
        end else begin
          add_vin = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (add_vout) begin
        data_d[idx_i] = add_res;
        if (!n_q[0] && ((i_q + 7'd1) == (n_q >> 1))) begin
          level_end = 1'b1;
        end else begin
          i_d     = i_q + 7'd1;
          state_d = S_ISSUE;
        end
      end
`ifdef FP_REDUCE_ACCUM_EN
      S_ACC: begin
        if (first_q) begin
          acc_d   = data_q[0];
          first_d = 1'b0;
          grp_end = 1'b1;
        end else begin
          add_a   = acc_q;
          add_b   = data_q[0];
          add_vin = 1'b1;
          state_d = S_ACC_W;
        end
      end
      S_ACC_W: if (add_vout) begin
        acc_d   = add_res;
        grp_end = 1'b1;
      end
`endif
      S_DONE: if (Out_Ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (level_end) begin
      n_d     = (n_q + 7'd1) >> 1;
      i_d     = 7'd0;
      state_d = (n_d == 7'd1) ? S_FIN : S_ISSUE;
    end
`ifdef FP_REDUCE_ACCUM_EN
    if (grp_end) begin
      if (last_q) begin
        state_d = S_DONE;
        first_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int k = 0; k < NUM_CH; k++) data_q[k] <= '0;
      n_q     <= '0;
      i_q     <= '0;
      rmode_q <= '0;
      run_q   <= 1'b0;
`ifdef FP_REDUCE_ACCUM_EN
      acc_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      n_q     <= n_d;
      i_q     <= i_d;
      rmode_q <= rmode_d;
      run_q   <= 1'b1;
`ifdef FP_REDUCE_ACCUM_EN
      acc_q   <= acc_d;
      first_q <= first_d;
      last_q  <= last_d;
`endif
    end
  end

  FP_Adder #(.LAT(ADD_LAT)) u_add (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (add_a),
    .B         (add_b),
    .Mode      (1'b0),
    .RMode     (rmode_q),
    .Valid_In  (add_vin),
    .Result    (add_res),
    .Valid_Out (add_vout)
  );

`ifdef FP_REDUCE_ACCUM_EN
  assign res_out = acc_q;
`else
  assign res_out = data_q[0];
`endif

  assign In_Ready  = run_q && (state_q == S_IDLE);
  assign Out_Valid = (state_q == S_DONE);
  assign Out_Data  = (state_q == S_DONE) ? res_out : '0;

endmodule
